fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end: PC generator, ROM address driver and a DEPTH-entry
//  {addr,inst} queue feeding decode through a valid/ready handshake. Replaces the bare pc + if_id
//  pair; a taken jump from ctrl flushes the queue and redirects fetch. Sits between ROM and id.
// PARAMETERS
//  XLEN      32           address/instruction width
//  DEPTH     4            queue entries; power of two, >= 2
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INST  32'h0000_0013  value on inst_o when queue empty (addi x0,x0,0)
// PORTS
//  clk           in   1                  clock
//  rstn          in   1                  reset, asynchronous, active-low
//  jump_en_i     in   1                  redirect request from ctrl
//  jump_addr_i   in   XLEN               redirect target; bits [1:0] ignored (treated as 0)
//  rom_addr_o    out  XLEN               ROM fetch address (= PC register)
//  rom_ren_o     out  1                  ROM read enable
//  rom_inst_i    in   XLEN               ROM data, combinational from rom_addr_o, same cycle
//  inst_valid_o  out  1                  queue head valid
//  inst_ready_i  in   1                  decode accepts head this cycle
//  inst_o        out  XLEN               head instruction
//  inst_addr_o   out  XLEN               head instruction address
//  count_o       out  $clog2(DEPTH)+1    occupied entries
//  fetch_cnt_o   out  32                 [FETCH_PERF_CNT_EN only] instructions enqueued
//  flush_cnt_o   out  32                 [FETCH_PERF_CNT_EN only] jumps taken
// BEHAVIOUR
//  - One clock, async active-low reset. Reset: PC=RESET_PC, count=0, rd/wr ptr=0, inst_valid_o=0,
//    inst_o=NOP_INST, inst_addr_o=0, rom_ren_o=1 (queue empty), perf counters=0.
//  - rom_ren_o = (count_o != DEPTH); depends on registered state only (no path from inst_ready_i).
//  - push = rom_ren_o & ~jump_en_i: store {PC, rom_inst_i} at wr ptr, PC <= PC+4 (mod 2^XLEN).
//  - pop = inst_valid_o & inst_ready_i & ~jump_en_i: advance rd ptr.
//  - inst_valid_o = (count_o != 0); inst_o/inst_addr_o = head entry, else NOP_INST / 0 when empty.
//  - push & pop same cycle: count unchanged, pointers both advance; legal even at count 0? no -
//    pop requires valid, so an empty queue never pops; a fetched word is visible next cycle.
//  - Latency: ROM word fetched in cycle N appears on inst_o in cycle N+1 (1-cycle, no bypass).
//  - Full: no fetch, PC held; resumes the cycle after count drops below DEPTH.
//  - jump_en_i (highest priority): next cycle count=0, ptrs=0, inst_valid_o=0, PC=jump_addr_i & ~3.
//    Same-cycle push and pop both discarded; decode handshake in that cycle has no effect.
//    Fetch resumes from target the following cycle; target visible 2 cycles after jump.
//  - Pointers wrap modulo DEPTH; count_o saturates logically at DEPTH (no overflow possible).
//  - Reset asserted mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined: fetch_cnt_o +1 per push, flush_cnt_o +1 per jump_en_i cycle,
//    both wrap at 2^32, cleared only by reset.
//  - Not defined: ports fetch_cnt_o/flush_cnt_o and their registers are absent.
// TESTING
//  1 reset release, ready=0, ROM=addr-pattern -> cycle0 rom_addr_o=0; cycle1 valid=1, inst_addr_o=0.
//  2 ready=0, DEPTH=4 -> count_o reaches 4, rom_ren_o=0, rom_addr_o holds 0x10; head stays addr 0.
//  3 ready=1 continuously -> one inst/cycle, inst_addr_o 0,4,8,...; count_o stays 1 after fill.
//  4 count=3, jump_en_i=1 jump_addr_i=0x103 -> next cycle valid=0, count=0, rom_addr_o=0x100;
//    cycle after, inst_addr_o=0x100.
//  5 RESET_PC=32'hFFFF_FFFC -> second fetch rom_addr_o=0x0000_0000 (wrap).
//  6 FETCH_PERF_CNT_EN: 10 pushes + 2 jumps -> fetch_cnt_o=10, flush_cnt_o=2; rstn low mid-run
//    -> all counters, count_o and PC return to reset values same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator, ROM fetch driver and DEPTH-entry {addr,inst} queue
// Optional perf counters (fetch_cnt_o, flush_cnt_o) built when FETCH_PERF_CNT_EN is defined.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013),
  localparam int             PW       = $clog2(DEPTH),
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic [XLEN-1:0] rom_addr_o,
  output logic            rom_ren_o,
  input  logic [XLEN-1:0] rom_inst_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [CW-1:0]   count_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  logic [XLEN-1:0] pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic            push;
  logic            pop;

  // Enable is a function of count only, so ready never reaches the ROM.
  assign rom_ren_o    = (count != CW'(DEPTH));
  assign rom_addr_o   = pc;
  assign inst_valid_o = (count != '0);
  assign count_o      = count;
  assign push         = rom_ren_o & ~jump_en_i;
  assign pop          = inst_valid_o & inst_ready_i & ~jump_en_i;
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? addr_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (jump_en_i) begin
      pc     <= jump_addr_i & ~XLEN'(3);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= pc;
      inst_mem[wr_ptr] <= rom_inst_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (push) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (jump_en_i) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam logic [31:0] PAT = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] rom_addr;
  logic        rom_ren;
  logic [31:0] rom_inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [2:0]  count;

  logic [31:0] rom_addr2;
  logic        rom_ren2;
  logic [31:0] rom_inst2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_addr2;
  logic [2:0]  count2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] fetch_cnt2;
  logic [31:0] flush_cnt2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rom_inst  = rom_addr ^ PAT;
  assign rom_inst2 = rom_addr2 ^ PAT;

  fetch_queue dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .rom_addr_o   (rom_addr),
    .rom_ren_o    (rom_ren),
    .rom_inst_i   (rom_inst),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .count_o      (count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (1'b0),
    .jump_addr_i  (32'h0),
    .rom_addr_o   (rom_addr2),
    .rom_ren_o    (rom_ren2),
    .rom_inst_i   (rom_inst2),
    .inst_valid_o (inst_valid2),
    .inst_ready_i (1'b0),
    .inst_o       (inst2),
    .inst_addr_o  (inst_addr2),
    .count_o      (count2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt2),
    .flush_cnt_o  (flush_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [2:0] n);
    check({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, ".addr"}, inst_addr, a);
    check({tag, ".inst"}, inst, a ^ PAT);
    check({tag, ".count"}, {29'b0, count}, {29'b0, n});
  endtask

  initial begin
    rstn       = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 32'h0;
    inst_ready = 1'b0;
    repeat (2) step();

    check("rst.count", {29'b0, count}, 32'd0);
    check("rst.valid", {31'b0, inst_valid}, 32'd0);
    check("rst.inst", inst, NOP);
    check("rst.inst_addr", inst_addr, 32'h0);
    check("rst.ren", {31'b0, rom_ren}, 32'd1);
    check("rst.rom_addr", rom_addr, 32'h0);
    check("rst.wrap_pc", rom_addr2, 32'hFFFF_FFFC);
    rstn = 1'b1;

    // Fill with decode stalled
    check("c0.rom_addr", rom_addr, 32'h0);
    step();
    check_head("fill1", 32'h0, 3'd1);
    check("fill1.rom_addr", rom_addr, 32'h4);
    check("wrap.rom_addr", rom_addr2, 32'h0);
    check("wrap.head", inst_addr2, 32'hFFFF_FFFC);
    step();
    check_head("fill2", 32'h0, 3'd2);
    step();
    check_head("fill3", 32'h0, 3'd3);
    step();
    check_head("fill4", 32'h0, 3'd4);
    check("full.ren", {31'b0, rom_ren}, 32'd0);
    check("full.rom_addr", rom_addr, 32'h10);
    step();
    check_head("full_hold", 32'h0, 3'd4);
    check("full_hold.rom_addr", rom_addr, 32'h10);

    // Drain while fetching
    inst_ready = 1'b1;
    step();
    check_head("drain1", 32'h4, 3'd3);
    check("drain1.ren", {31'b0, rom_ren}, 32'd1);
    check("drain1.rom_addr", rom_addr, 32'h10);
    step();
    check_head("drain2", 32'h8, 3'd3);
    check("drain2.rom_addr", rom_addr, 32'h14);
    step();
    check_head("drain3", 32'hC, 3'd3);

    // Redirect with count=3; handshake in the jump cycle is discarded
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0103;
    step();
    jump_en = 1'b0;
    check("jmp.valid", {31'b0, inst_valid}, 32'd0);
    check("jmp.count", {29'b0, count}, 32'd0);
    check("jmp.rom_addr", rom_addr, 32'h100);
    check("jmp.inst", inst, NOP);
    check("jmp.inst_addr", inst_addr, 32'h0);
    step();
    check_head("tgt1", 32'h100, 3'd1);
    step();
    check_head("tgt2", 32'h104, 3'd1);
    step();
    check_head("tgt3", 32'h108, 3'd1);
    step();
    check_head("tgt4", 32'h10C, 3'd1);

    jump_en   = 1'b1;
    jump_addr = 32'h0000_0202;
    step();
    jump_en = 1'b0;
    check("jmp2.count", {29'b0, count}, 32'd0);
    check("jmp2.rom_addr", rom_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
    check("perf.fetch", fetch_cnt, 32'd10);
    check("perf.flush", flush_cnt, 32'd2);
`endif
    step();
    check_head("tgt5", 32'h200, 3'd1);

    // Asynchronous reset mid-run, sampled before any clock edge
    rstn = 1'b0;
    #1;
    check("arst.count", {29'b0, count}, 32'd0);
    check("arst.valid", {31'b0, inst_valid}, 32'd0);
    check("arst.rom_addr", rom_addr, 32'h0);
    check("arst.inst", inst, NOP);
    check("arst.wrap_pc", rom_addr2, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
    check("arst.fetch", fetch_cnt, 32'd0);
    check("arst.flush", flush_cnt, 32'd0);
`endif
    #1;
    rstn = 1'b1;
    inst_ready = 1'b0;
    step();
    check_head("post_rst", 32'h0, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
